// File: rtl/decoder_pkg.sv
// decoder_pkg
// Shared types and default parameter values for the receive decoder sample
// sequencer (decoder_sample_ctrl and its sample_period_timer).
package decoder_pkg;

  // Sequencer states: idle, conversion in flight, waiting for the next period
  // tick, and latched fault (overrun) awaiting a stop.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } samp_state_t;

  localparam int DEF_DIV_W   = 8;
  localparam int DEF_MIN_DIV = 4;
  localparam int DEF_WARMUP  = 16;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/decoder_sample_ctrl_timer.sv
// sample_period_timer
// Free-running modulo-div counter that marks the last cycle of each sample
// period. restart forces the count to 0 for the next cycle; the count only
// advances while enabled.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   restart    : force count to 0 at the next edge (wins over enable)
//   enable     : count while high
//   div        : period length in cycles (caller guarantees div >= 1)
//   tick       : high while enabled and count == div-1
module sample_period_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  assign tick = enable && (count == div - DIV_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/decoder_sample_ctrl.sv
// decoder_sample_ctrl
// Sequences the receive decoder datapath: issues ADC start-of-conversion
// pulses every div cycles, forwards qualified end-of-conversion as the
// decoder sample strobe, masks FIR warm-up outputs and flags overrun and
// spurious-EOC faults.
// Ports:
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_start, i_stop    : begin sampling (IDLE only) / abort from any state
//   i_cfg_div          : sample period, latched (clamped to MIN_DIV) on start
//   o_adc_soc          : 1-cycle ADC start-of-conversion pulse
//   i_adc_eoc          : ADC end-of-conversion pulse
//   o_dec_eoc          : registered sample strobe to decoder_top
//   i_postfilter_ready : decoder_top postfilter output strobe
//   o_bb_valid         : postfilter_ready once the FIR has warmed up
//   o_busy             : sequencer not idle
//   o_overrun          : sticky, period elapsed before EOC
//   o_spurious         : sticky, EOC while waiting for the period tick
//   o_sample_cnt       : forwarded samples since start (saturating)
module decoder_sample_ctrl
  import decoder_pkg::*;
#(
  parameter int DIV_W   = DEF_DIV_W,
  parameter int MIN_DIV = DEF_MIN_DIV,
  parameter int WARMUP  = DEF_WARMUP,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [DIV_W-1:0] i_cfg_div,
  output logic             o_adc_soc,
  input  logic             i_adc_eoc,
  output logic             o_dec_eoc,
  input  logic             i_postfilter_ready,
  output logic             o_bb_valid,
  output logic             o_busy,
  output logic             o_overrun,
  output logic             o_spurious,
  output logic [CNT_W-1:0] o_sample_cnt
);

  localparam int WARM_W = $clog2(WARMUP + 1);

  samp_state_t      state, state_next;
  logic [DIV_W-1:0] div_q;
  logic [WARM_W-1:0] warm_cnt;
  logic             tick, running, warm;
  logic             soc_next, dec_eoc_next, start_acc, cnt_inc, set_overrun, set_spurious;

  assign running    = (state == CONV) || (state == HOLD);
  assign warm       = (warm_cnt >= WARM_W'(WARMUP));
  assign o_busy     = (state != IDLE);
  assign o_bb_valid = i_postfilter_ready && warm && running;

  sample_period_timer #(.DIV_W(DIV_W)) u_timer (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .restart (start_acc),
    .enable  (running),
    .div     (div_q),
    .tick    (tick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stop beats everything, including an EOC or tick in the same cycle, so an
  // abandoned conversion never produces a strobe or a fault.
  // An EOC coinciding with the period tick is treated as on time.
  always_comb begin
    state_next   = state;
    soc_next     = 1'b0;
    dec_eoc_next = 1'b0;
    start_acc    = 1'b0;
    cnt_inc      = 1'b0;
    set_overrun  = 1'b0;
    set_spurious = 1'b0;
    if (i_stop) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_start) begin
            state_next = CONV;
            soc_next   = 1'b1;
            start_acc  = 1'b1;
          end
        end
        CONV: begin
          if (i_adc_eoc) begin
            state_next   = HOLD;
            dec_eoc_next = 1'b1;
            cnt_inc      = 1'b1;
          end else if (tick) begin
            state_next  = ERR;
            set_overrun = 1'b1;
          end
        end
        HOLD: begin
          if (i_adc_eoc) begin
            set_spurious = 1'b1;
          end
          if (tick) begin
            state_next = CONV;
            soc_next   = 1'b1;
          end
        end
        ERR: begin
          state_next = ERR;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Registered pulses, latched period, counters and sticky flags. All are
  // cleared on an accepted start and otherwise hold across a stop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_adc_soc    <= 1'b0;
      o_dec_eoc    <= 1'b0;
      div_q        <= DIV_W'(MIN_DIV);
      o_sample_cnt <= '0;
      o_overrun    <= 1'b0;
      o_spurious   <= 1'b0;
      warm_cnt     <= '0;
    end else begin
      o_adc_soc <= soc_next;
      o_dec_eoc <= dec_eoc_next;
      if (start_acc) begin
        div_q        <= (i_cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : i_cfg_div;
        o_sample_cnt <= '0;
        o_overrun    <= 1'b0;
        o_spurious   <= 1'b0;
        warm_cnt     <= '0;
      end else begin
        if (cnt_inc && (o_sample_cnt != {CNT_W{1'b1}})) begin
          o_sample_cnt <= o_sample_cnt + CNT_W'(1);
        end
        if (set_overrun) begin
          o_overrun <= 1'b1;
        end
        if (set_spurious) begin
          o_spurious <= 1'b1;
        end
        if (o_busy && i_postfilter_ready && !warm) begin
          warm_cnt <= warm_cnt + WARM_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_decoder_sample_ctrl.sv
// tb_decoder_sample_ctrl
// Scoreboard bench: each scenario plans its EOC and postfilter_ready traffic
// up front, derives from the sequencing rules the cycles on which SOC,
// decoder strobe and baseband-valid must appear, and queues them. A monitor
// on the falling edge pops and compares whenever the DUT raises one of those
// outputs; scenario-end checks cover counters, sticky flags and drained queues.
module tb_decoder_sample_ctrl;

  localparam int WARMUP = 16;

  logic        clk = 1'b0;
  logic        i_rst_n, i_start, i_stop, i_adc_eoc, i_postfilter_ready;
  logic [7:0]  i_cfg_div;
  logic        o_adc_soc, o_dec_eoc, o_bb_valid, o_busy, o_overrun, o_spurious;
  logic [15:0] o_sample_cnt;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  int socQ[$];
  int decQ[$];
  int bbQ[$];

  bit eocArr[512];
  bit readyArr[512];

  decoder_sample_ctrl dut (
    .i_clk              (clk),
    .i_rst_n            (i_rst_n),
    .i_start            (i_start),
    .i_stop             (i_stop),
    .i_cfg_div          (i_cfg_div),
    .o_adc_soc          (o_adc_soc),
    .i_adc_eoc          (i_adc_eoc),
    .o_dec_eoc          (o_dec_eoc),
    .i_postfilter_ready (i_postfilter_ready),
    .o_bb_valid         (o_bb_valid),
    .o_busy             (o_busy),
    .o_overrun          (o_overrun),
    .o_spurious         (o_spurious),
    .o_sample_cnt       (o_sample_cnt)
  );

  // 10-unit clock; cycle index advances on every rising edge
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic applyStimulus(input bit start, input bit stop, input bit eoc, input bit ready);
    i_start            = start;
    i_stop             = stop;
    i_adc_eoc          = eoc;
    i_postfilter_ready = ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe the DUT raises must match the next predicted cycle
  always @(negedge clk) begin
    if (i_rst_n) begin
      if (o_adc_soc) begin
        if (socQ.size() == 0) checkOutput("soc_unexpected", cyc, -1);
        else checkOutput("soc_cycle", cyc, socQ.pop_front());
      end
      if (o_dec_eoc) begin
        if (decQ.size() == 0) checkOutput("dec_eoc_unexpected", cyc, -1);
        else checkOutput("dec_eoc_cycle", cyc, decQ.pop_front());
      end
      if (o_bb_valid) begin
        if (bbQ.size() == 0) checkOutput("bb_valid_unexpected", cyc, -1);
        else checkOutput("bb_valid_cycle", cyc, bbQ.pop_front());
      end
    end
  end

  // One start..stop run. Period k starts with SOC; the EOC lands d cycles
  // later. d == D-1 coincides with the period tick: on time, but the next SOC
  // then waits a whole further period. A withheld EOC means overrun one
  // period after its SOC, with no further SOCs until stop.
  task automatic runScenario(input string tag, input int cfgDiv, input int nPer,
                             input int withholdAt, input int tickAt, input bit addSpur,
                             input int fixedD, input int readyPct);
    int  D, s, soc, d, e, p, errC, runEnd, last, cw, expCnt, c;
    bit  withheld, expSpur;
    D = (cfgDiv < 4) ? 4 : cfgDiv;
    s = cyc;
    soc = s + 1;
    expCnt = 0;
    withheld = 0;
    expSpur = 0;
    errC = 0;
    for (int off = 0; off < 512; off++) begin
      eocArr[off]   = 0;
      readyArr[off] = 0;
    end
    for (int k = 0; k < nPer; k++) begin
      socQ.push_back(soc);
      if (k == withholdAt) begin
        withheld = 1;
        errC = soc + D;
        break;
      end
      if (k == tickAt) d = D - 1;
      else if (addSpur && k == 0) d = $urandom_range(0, D - 2);
      else if (fixedD >= 0) d = fixedD;
      else d = $urandom_range(0, D - 1);
      e = soc + d;
      eocArr[e - s] = 1;
      decQ.push_back(e + 1);
      expCnt++;
      if (addSpur && k == 0 && k != tickAt) begin
        eocArr[e + 1 - s] = 1;
        expSpur = 1;
      end
      soc = (d == D - 1) ? soc + 2 * D : soc + D;
    end
    if (withheld) begin
      p = errC + 3;
      eocArr[errC + 1 - s] = 1;
      runEnd = errC - 1;
    end else begin
      p = soc - 1;
      runEnd = p;
    end
    eocArr[p + 1 - s] = 1;
    last = p + 2 - s;
    for (int off = 0; off <= last; off++) readyArr[off] = ($urandom_range(0, 99) < readyPct);
    cw = 0;
    for (int off = 0; off <= last; off++) begin
      c = s + off;
      if (readyArr[off]) begin
        if (c >= s + 1 && c <= runEnd && cw >= WARMUP) bbQ.push_back(c);
        if (c >= s + 1 && c <= p && cw < WARMUP) cw++;
      end
    end
    i_cfg_div = 8'(cfgDiv);
    for (int off = 0; off <= last; off++) begin
      applyStimulus(off == 0 || off == 2, (s + off) == p, eocArr[off], readyArr[off]);
      if (withheld && (s + off) == p) begin
        checkOutput({tag, "_err_busy"}, int'(o_busy), 1);
        checkOutput({tag, "_err_overrun"}, int'(o_overrun), 1);
      end
      step();
    end
    applyStimulus(0, 0, 0, 0);
    step();
    checkOutput({tag, "_sample_cnt"}, int'(o_sample_cnt), expCnt);
    checkOutput({tag, "_overrun"}, int'(o_overrun), int'(withheld));
    checkOutput({tag, "_spurious"}, int'(o_spurious), int'(expSpur));
    checkOutput({tag, "_busy_after_stop"}, int'(o_busy), 0);
    checkOutput({tag, "_soc_left"}, socQ.size(), 0);
    checkOutput({tag, "_dec_left"}, decQ.size(), 0);
    checkOutput({tag, "_bb_left"}, bbQ.size(), 0);
    socQ.delete();
    decQ.delete();
    bbQ.delete();
  endtask

  initial begin
    int s, nP, wh, tk;
    i_rst_n = 1'b0;
    i_cfg_div = 8'd0;
    applyStimulus(0, 0, 0, 0);
    repeat (3) step();

    // Reset state
    checkOutput("rst_busy", int'(o_busy), 0);
    checkOutput("rst_soc", int'(o_adc_soc), 0);
    checkOutput("rst_dec_eoc", int'(o_dec_eoc), 0);
    checkOutput("rst_cnt", int'(o_sample_cnt), 0);
    checkOutput("rst_overrun", int'(o_overrun), 0);
    checkOutput("rst_spurious", int'(o_spurious), 0);
    i_rst_n = 1'b1;
    step();

    // Directed runs: steady sampling, clamping, overrun, tick/spurious, warm-up
    runScenario("basic", 8, 10, -1, -1, 0, 3, 40);
    runScenario("clamp", 2, 5, -1, -1, 0, -1, 40);
    runScenario("overrun", 8, 4, 1, -1, 0, 3, 40);
    runScenario("tick_spur", 8, 4, -1, 1, 1, -1, 40);
    runScenario("warmup", 8, 4, -1, -1, 0, 3, 100);

    // Randomised runs
    for (int r = 0; r < 8; r++) begin
      nP = $urandom_range(2, 8);
      wh = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nP - 1) : -1;
      tk = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nP - 1) : -1;
      runScenario("rand", $urandom_range(0, 12), nP, wh, tk, 1'($urandom_range(0, 1)), -1,
                  $urandom_range(20, 90));
    end

    // Start and stop together in IDLE: stop wins, nothing starts
    applyStimulus(1, 1, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0);
    checkOutput("start_stop_busy", int'(o_busy), 0);
    step();
    checkOutput("start_stop_busy_later", int'(o_busy), 0);

    // Asynchronous reset in the middle of a conversion
    i_cfg_div = 8'd8;
    s = cyc;
    socQ.push_back(s + 1);
    applyStimulus(1, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0);
    step();
    checkOutput("conv_busy", int'(o_busy), 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", int'(o_busy), 0);
    checkOutput("arst_soc", int'(o_adc_soc), 0);
    checkOutput("arst_dec_eoc", int'(o_dec_eoc), 0);
    checkOutput("arst_cnt", int'(o_sample_cnt), 0);
    checkOutput("arst_overrun", int'(o_overrun), 0);
    checkOutput("arst_spurious", int'(o_spurious), 0);
    checkOutput("arst_soc_left", socQ.size(), 0);
    step();
    i_rst_n = 1'b1;
    step();
    step();
    checkOutput("post_rst_busy", int'(o_busy), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
